led_pattern_sequencer: RTL

LED_PATTERN_SEQUENCER -- requirements
Module: led_pattern_sequencer

---
 rtl/led_pattern_sequencer_pkg.sv | 29 ++
 rtl/led_pattern_sequencer_btn_debounce.sv | 40 ++++
 rtl/led_pattern_sequencer.sv | 119 +++++++++++
 3 files changed

// File: rtl/led_pattern_sequencer_pkg.sv
// Shared definitions for the LED pattern sequencer: FSM encoding, playlist
// entry layout and the circular next-enabled-slot search.
package led_pattern_sequencer_pkg;

    localparam int NUM_SLOTS = 4;
    localparam int MODE_MSB  = 7;
    localparam int MODE_LSB  = 6;
    localparam int DWELL_MSB = 5;
    localparam int DWELL_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10
    } state_e;

    typedef logic [1:0] slot_t;

    // First enabled slot in order base+1, base+2, base+3, base; base if none.
    function automatic slot_t next_slot(input logic [NUM_SLOTS-1:0] en, input slot_t base);
        slot_t s;
        next_slot = base;
        for (int k = NUM_SLOTS; k >= 1; k--) begin
            s = slot_t'(32'(base) + k);
            if (en[s]) next_slot = s;
        end
    endfunction

endpackage

// File: rtl/led_pattern_sequencer_btn_debounce.sv
// Two-flop synchroniser plus stability filter for a raw push-button; emits a
// single-cycle pulse on the edge where a new high level is accepted.
module btn_debounce #(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_ena,
    input  logic i_btn,
    output logic o_rise
);

    logic [1:0] r_sync;
    logic       r_level;
    logic [7:0] r_cnt;
    logic       w_accept;

    // Accept once the synchronised level has differed for DEBOUNCE cycles.
    assign w_accept = i_ena && (r_sync[1] != r_level) && ((r_cnt + 8'd1) >= 8'(DEBOUNCE));
    assign o_rise   = w_accept && r_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (i_ena) begin
            r_sync <= {r_sync[0], i_btn};
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Playlist-driven sequencer: steps a pattern engine at a prescaled rate and
// walks a 4-slot playlist by dwell expiry or a debounced manual button.
module led_pattern_sequencer
    import led_pattern_sequencer_pkg::*;
#(
    parameter int PRESCALE = 16,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       cfg_wr,
    input  logic [1:0] cfg_addr,
    input  logic [7:0] cfg_data,
    input  logic       run,
    input  logic       adv_btn,
    output logic [1:0] pat_mode,
    output logic       pat_step,
    output logic [1:0] slot,
    output logic [1:0] state
);

    localparam int            PW      = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    logic [7:0]           r_pl [NUM_SLOTS];
    state_e               r_state;
    slot_t                r_slot;
    logic [1:0]           r_mode;
    logic [PW-1:0]        r_pre;
    logic [5:0]           r_dwell;

    logic [NUM_SLOTS-1:0] w_en;
    logic                 w_all_zero;
    logic                 w_rise;
    logic                 w_step;
    logic                 w_expire;
    logic                 w_adv;
    logic [5:0]           w_cur_dwell;
    slot_t                w_next;
    slot_t                w_first;

    always_comb begin
        w_en = '0;
        for (int i = 0; i < NUM_SLOTS; i++) w_en[i] = |r_pl[i][DWELL_MSB:DWELL_LSB];
    end

    assign w_all_zero  = ~|w_en;
    assign w_cur_dwell = r_pl[r_slot][DWELL_MSB:DWELL_LSB];
    assign w_next      = next_slot(w_en, r_slot);
    assign w_first     = next_slot(w_en, 2'd3);

    // Step only when this cycle actually counts (not on the edge leaving RUN).
    assign w_step   = ena && (r_state == ST_RUN) && run && !w_all_zero && (r_pre == PRE_MAX);
    assign w_expire = w_step && (({1'b0, r_dwell} + 7'd1) >= {1'b0, w_cur_dwell});
    assign w_adv    = ena && (r_state != ST_IDLE) && !w_all_zero && (w_expire || w_rise);

    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_btn (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_ena  (ena),
        .i_btn  (adv_btn),
        .o_rise (w_rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) r_pl[i] <= '0;
        end else if (cfg_wr) begin
            r_pl[cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_slot  <= '0;
            r_mode  <= '0;
            r_pre   <= '0;
            r_dwell <= '0;
        end else if (ena) begin
            case (r_state)
                ST_IDLE: begin
                    r_pre   <= '0;
                    r_dwell <= '0;
                    if (run && !w_all_zero) begin
                        r_state <= ST_RUN;
                        r_slot  <= w_first;
                        r_mode  <= r_pl[w_first][MODE_MSB:MODE_LSB];
                    end
                end
                default: begin
                    if (w_all_zero) begin
                        r_state <= ST_IDLE;
                        r_pre   <= '0;
                        r_dwell <= '0;
                    end else begin
                        r_state <= run ? ST_RUN : ST_HOLD;
                        if (w_adv) begin
                            r_slot  <= w_next;
                            r_mode  <= r_pl[w_next][MODE_MSB:MODE_LSB];
                            r_pre   <= '0;
                            r_dwell <= '0;
                        end else if (r_state == ST_RUN && run) begin
                            r_pre <= w_step ? '0 : r_pre + 1'b1;
                            if (w_step) r_dwell <= r_dwell + 6'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign pat_step = w_step;
    assign pat_mode = r_mode;
    assign slot     = r_slot;
    assign state    = r_state;

endmodule
